// File: rtl/temp_cipher_pkg.sv
// Shared definitions for the temperature/cipher/UART scheduler:
// FSM state encoding, plaintext frame layout and small helpers.
package temp_cipher_pkg;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE         = 3'd0;
   localparam state_t ST_WAIT_TEMP    = 3'd1;
   localparam state_t ST_ENCRYPT      = 3'd2;
   localparam state_t ST_WAIT_CIPH    = 3'd3;
   localparam state_t ST_SEND         = 3'd4;
   localparam state_t ST_WAIT_BUSY_HI = 3'd5;
   localparam state_t ST_WAIT_BUSY_LO = 3'd6;

   localparam logic [7:0] FRAME_TAG_DEFAULT = 8'hA5;

   // Plaintext frame: {tag[63:56], seq[55:40], zero[39:20], temp[19:0]}
   localparam int BLOCK_W  = 64;
   localparam int TAG_W    = 8;
   localparam int SEQ_W    = 16;
   localparam int TEMP_W   = 20;
   localparam int TAG_LSB  = 56;
   localparam int SEQ_LSB  = 40;
   localparam int TEMP_LSB = 0;

   // Assemble one plaintext block from its fields; unused bits stay zero.
   function automatic logic [BLOCK_W-1:0] build_plaintext(
      input logic [TAG_W-1:0]  tag,
      input logic [SEQ_W-1:0]  seq,
      input logic [TEMP_W-1:0] temp
   );
      logic [BLOCK_W-1:0] pt;
      pt                     = '0;
      pt[TAG_LSB  +: TAG_W]  = tag;
      pt[SEQ_LSB  +: SEQ_W]  = seq;
      pt[TEMP_LSB +: TEMP_W] = temp;
      return pt;
   endfunction

   // States in which the abort timer runs.
   function automatic logic is_wait_state(input state_t st);
      return (st == ST_WAIT_TEMP) || (st == ST_WAIT_CIPH) || (st == ST_SEND) ||
             (st == ST_WAIT_BUSY_HI) || (st == ST_WAIT_BUSY_LO);
   endfunction

endpackage

// File: rtl/sched_tick_gen.sv
// Free-running period counter: counts 0..PERIOD_CYCLES-1 and raises
// tick for the single cycle in which it wraps.
module sched_tick_gen #(
   parameter int PERIOD_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int               CNT_W = $clog2(PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Period counter; never stalled by the consumer of tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/temp_cipher_sched.sv
// Scheduler for the temperature -> cipher -> UART path. Each period tick
// starts one transaction (sample, frame, encrypt, send); ticks arriving
// while a transaction is in flight are counted as overruns. Every wait
// state is bounded by an abort timer that sets a sticky error flag.
module temp_cipher_sched
   import temp_cipher_pkg::*;
#(
   parameter int         PERIOD_CYCLES  = 10_000_000,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0] FRAME_TAG      = FRAME_TAG_DEFAULT
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   output logic        temp_req,
   input  logic        temp_valid,
   input  logic [19:0] temp_data,
   output logic        cipher_start,
   output logic [63:0] cipher_din,
   input  logic        cipher_done,
   input  logic [63:0] cipher_dout,
   output logic        uart_send_en,
   output logic [63:0] uart_send_data,
   input  logic        uart_tx_busy,
   output logic [31:0] disp_data,
   output logic        disp_en,
   output logic [15:0] seq_cnt,
   output logic [7:0]  overrun_cnt,
   output logic        err
);

   localparam int                WAIT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   logic              tick;
   logic              abort;
   logic              timed_out;
   logic [WAIT_W-1:0] wait_cnt;

   sched_tick_gen #(
      .PERIOD_CYCLES (PERIOD_CYCLES)
   ) u_tick_gen (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .tick  (tick)
   );

   // The wait counter has reached its limit in the current cycle.
   assign timed_out = (wait_cnt == TIMEOUT_LAST);

   // FSM state register.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the expected event wins over a same-cycle timeout.
   always_comb begin
      state_next = state;
      abort      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (tick) state_next = ST_WAIT_TEMP;
         end
         ST_WAIT_TEMP: begin
            if (temp_valid)     state_next = ST_ENCRYPT;
            else if (timed_out) abort      = 1'b1;
         end
         ST_ENCRYPT: begin
            state_next = ST_WAIT_CIPH;
         end
         ST_WAIT_CIPH: begin
            if (cipher_done)    state_next = ST_SEND;
            else if (timed_out) abort      = 1'b1;
         end
         ST_SEND: begin
            if (!uart_tx_busy)  state_next = ST_WAIT_BUSY_HI;
            else if (timed_out) abort      = 1'b1;
         end
         ST_WAIT_BUSY_HI: begin
            if (uart_tx_busy)   state_next = ST_WAIT_BUSY_LO;
            else if (timed_out) abort      = 1'b1;
         end
         ST_WAIT_BUSY_LO: begin
            if (!uart_tx_busy)  state_next = ST_IDLE;
            else if (timed_out) abort      = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (abort) state_next = ST_IDLE;
   end

   // Single-cycle strobes decoded from the current state.
   always_comb begin
      cipher_start = 1'b0;
      uart_send_en = 1'b0;
      case (state)
         ST_ENCRYPT: cipher_start = 1'b1;
         ST_SEND:    uart_send_en = !uart_tx_busy;
         default:    ;
      endcase
   end

   // Abort timer: cleared on every state change, counts while waiting.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         wait_cnt <= '0;
      end else if (state_next != state) begin
         wait_cnt <= '0;
      end else if (is_wait_state(state) && !timed_out) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Sensor request: one cycle after a tick accepted in IDLE.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         temp_req <= 1'b0;
      end else begin
         temp_req <= (state == ST_IDLE) && tick;
      end
   end

   // Reading capture: display value and plaintext frame, held until the next reading.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         disp_data  <= '0;
         disp_en    <= 1'b0;
         cipher_din <= '0;
      end else if ((state == ST_WAIT_TEMP) && temp_valid) begin
         disp_data  <= {12'h000, temp_data};
         disp_en    <= 1'b1;
         cipher_din <= build_plaintext(FRAME_TAG, seq_cnt, temp_data);
      end
   end

   // Ciphertext capture for the UART sender.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         uart_send_data <= '0;
      end else if ((state == ST_WAIT_CIPH) && cipher_done) begin
         uart_send_data <= cipher_dout;
      end
   end

   // Completed-transaction counter; wraps naturally at 16 bits.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         seq_cnt <= '0;
      end else if ((state == ST_WAIT_BUSY_LO) && !uart_tx_busy) begin
         seq_cnt <= seq_cnt + 1'b1;
      end
   end

   // Dropped-tick counter, saturating at all ones.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         overrun_cnt <= '0;
      end else if (tick && (state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 1'b1;
      end
   end

   // Sticky error flag raised by any timeout abort.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         err <= 1'b0;
      end else if (abort) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_temp_cipher_sched.sv
// Bench for temp_cipher_sched: randomized sensor/cipher/UART responders,
// a scoreboard of expected plaintext/ciphertext and a cycle-level model
// of tick timing, overruns, sequence count and error state.
`timescale 1ns/1ps
module tb_temp_cipher_sched;

   localparam int PERIOD  = 100;
   localparam int TIMEOUT = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        temp_req;
   logic        temp_valid = 1'b0;
   logic [19:0] temp_data = '0;
   logic        cipher_start;
   logic [63:0] cipher_din;
   logic        cipher_done = 1'b0;
   logic [63:0] cipher_dout = '0;
   logic        uart_send_en;
   logic [63:0] uart_send_data;
   logic        uart_tx_busy = 1'b0;
   logic [31:0] disp_data;
   logic        disp_en;
   logic [15:0] seq_cnt;
   logic [7:0]  overrun_cnt;
   logic        err;

   temp_cipher_sched #(
      .PERIOD_CYCLES  (PERIOD),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FRAME_TAG      (8'hA5)
   ) dut (
      .CLK100MHZ      (clk),
      .CPU_RESETN     (rst_n),
      .temp_req       (temp_req),
      .temp_valid     (temp_valid),
      .temp_data      (temp_data),
      .cipher_start   (cipher_start),
      .cipher_din     (cipher_din),
      .cipher_done    (cipher_done),
      .cipher_dout    (cipher_dout),
      .uart_send_en   (uart_send_en),
      .uart_send_data (uart_send_data),
      .uart_tx_busy   (uart_tx_busy),
      .disp_data      (disp_data),
      .disp_en        (disp_en),
      .seq_cnt        (seq_cnt),
      .overrun_cnt    (overrun_cnt),
      .err            (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_din_q[$];
   logic [63:0] exp_uart_q[$];

   logic [15:0] seq_model   = '0;
   int          ov_model    = 0;
   logic        err_model   = 1'b0;
   int          exp_req     = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   endtask

   // Advance to the input-drive point of the next cycle.
   task automatic cyc_drive();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected block.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cipher_start) begin
            if (exp_din_q.size() == 0) check64("unexpected_cipher_start", 64'd1, 64'd0);
            else check64("cipher_din", cipher_din, exp_din_q.pop_front());
         end
         if (uart_send_en) begin
            if (exp_uart_q.size() == 0) check64("unexpected_uart_send_en", 64'd1, 64'd0);
            else check64("uart_send_data", uart_send_data, exp_uart_q.pop_front());
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check64({tag, "_temp_req"},       temp_req,       '0);
      check64({tag, "_cipher_start"},   cipher_start,   '0);
      check64({tag, "_cipher_din"},     cipher_din,     '0);
      check64({tag, "_uart_send_en"},   uart_send_en,   '0);
      check64({tag, "_uart_send_data"}, uart_send_data, '0);
      check64({tag, "_disp_data"},      disp_data,      '0);
      check64({tag, "_disp_en"},        disp_en,        '0);
      check64({tag, "_seq_cnt"},        seq_cnt,        '0);
      check64({tag, "_overrun_cnt"},    overrun_cnt,    '0);
      check64({tag, "_err"},            err,            '0);
   endtask

   // Wait for the sensor request and compare its cycle with the tick model.
   task automatic wait_temp_req(output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int k = 0; k < 4 * PERIOD; k++) begin
         @(negedge clk);
         if (temp_req) begin
            found = 1'b1;
            n = cyc;
            break;
         end
      end
      if (!found) begin
         check64("temp_req_timeout", 64'd0, 64'd1);
         finish_run();
      end
      check64("temp_req_cycle", n, exp_req);
   endtask

   // Transaction accounting: ticks falling in [n, last busy cycle] are dropped.
   task automatic close_txn(input int n, input int last_busy);
      int drops;
      drops    = (last_busy - n + 1) / PERIOD;
      ov_model = (ov_model + drops > 255) ? 255 : ov_model + drops;
      exp_req  = n + PERIOD * (drops + 1);
      check64("overrun_cnt", overrun_cnt, ov_model);
      check64("err", err, err_model);
      check64("seq_cnt", seq_cnt, seq_model);
   endtask

   // One full transaction with the given responder delays.
   task automatic run_txn(input int d1, input bit spur, input int d2,
                          input int stall, input int h, input int b);
      int          n, c;
      bit          bad;
      logic [19:0] data;
      logic [63:0] ct;
      wait_temp_req(n);
      data = 20'($urandom);
      exp_din_q.push_back({8'hA5, seq_model, 20'h00000, data});
      cyc_drive();
      @(negedge clk);
      check64("temp_req_width", temp_req, 1'b0);
      if (spur) begin
         cyc_drive(); cipher_done = 1'b1; cipher_dout = {$urandom, $urandom};
         cyc_drive(); cipher_done = 1'b0;
      end
      repeat (d1) cyc_drive();
      cyc_drive(); temp_valid = 1'b1; temp_data = data;
      cyc_drive(); temp_valid = 1'b0; temp_data = 20'($urandom);
      @(negedge clk);
      check64("start_latency", cipher_start, 1'b1);
      check64("disp_data", disp_data, {12'h000, data});
      check64("disp_en", disp_en, 1'b1);
      if (spur) begin
         cyc_drive(); temp_valid = 1'b1; temp_data = 20'($urandom);
         cyc_drive(); temp_valid = 1'b0;
      end
      repeat (d2) cyc_drive();
      ct = {$urandom, $urandom};
      cyc_drive(); cipher_done = 1'b1; cipher_dout = ct; exp_uart_q.push_back(ct);
      if (stall > 0) uart_tx_busy = 1'b1;
      cyc_drive(); cipher_done = 1'b0; cipher_dout = {$urandom, $urandom};
      @(negedge clk);
      check64("send_latency", uart_send_en, (stall == 0));
      if (stall > 0) begin
         bad = 1'b0;
         repeat (stall - 1) begin
            cyc_drive();
            @(negedge clk);
            if (uart_send_en) bad = 1'b1;
         end
         check64("send_held_while_busy", bad, 1'b0);
         cyc_drive(); uart_tx_busy = 1'b0;
         @(negedge clk);
         check64("send_on_release", uart_send_en, 1'b1);
      end
      repeat (h) cyc_drive();
      cyc_drive(); uart_tx_busy = 1'b1;
      @(negedge clk);
      check64("send_single_pulse", uart_send_en, 1'b0);
      repeat (b) cyc_drive();
      cyc_drive(); uart_tx_busy = 1'b0; c = cyc;
      seq_model = seq_model + 16'd1;
      cyc_drive();
      @(negedge clk);
      check64("uart_data_held", uart_send_data, ct);
      check64("disp_data_kept", disp_data, {12'h000, data});
      close_txn(n, c);
   endtask

   // Silent sensor: abort after TIMEOUT cycles in WAIT_TEMP.
   task automatic run_timeout();
      int n, k;
      wait_temp_req(n);
      k = 0;
      while (k < 4 * TIMEOUT) begin
         @(negedge clk);
         k++;
         if (err) break;
      end
      check64("timeout_cycles", k, TIMEOUT);
      err_model = 1'b1;
      close_txn(n, n + TIMEOUT - 1);
   endtask

   // Reset asserted while waiting for the cipher core.
   task automatic run_reset_mid_cipher();
      int          n;
      bit          bad;
      logic [19:0] data;
      wait_temp_req(n);
      data = 20'($urandom);
      exp_din_q.push_back({8'hA5, seq_model, 20'h00000, data});
      cyc_drive(); temp_valid = 1'b1; temp_data = data;
      cyc_drive(); temp_valid = 1'b0;
      @(negedge clk);
      check64("rst_test_start", cipher_start, 1'b1);
      cyc_drive();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      seq_model = '0; ov_model = 0; err_model = 1'b0;
      exp_din_q.delete(); exp_uart_q.delete();
      repeat (3) cyc_drive();
      rst_n = 1'b1;
      exp_req = cyc + PERIOD;
      repeat (4) cyc_drive();
      cipher_done = 1'b1; cipher_dout = {$urandom, $urandom};
      cyc_drive(); cipher_done = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (uart_send_en || cipher_start || temp_req) bad = 1'b1;
         cyc_drive();
      end
      check64("late_done_ignored", bad, 1'b0);
      check64("late_done_no_latch", uart_send_data, '0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      cyc_drive();
      rst_n = 1'b1;
      exp_req = cyc + PERIOD;
      for (int i = 0; i < 6; i++) begin
         run_txn($urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 (i == 1) ? 4 : $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(1, 10));
      end
      run_timeout();
      run_txn($urandom_range(0, 10), 1'b0, $urandom_range(0, 15), 0, 1, 3);
      for (int i = 0; i < 130; i++) begin
         run_txn($urandom_range(40, 44), 1'b0, $urandom_range(40, 44), $urandom_range(40, 44),
                 $urandom_range(40, 44), $urandom_range(40, 44));
      end
      check64("overrun_saturated", overrun_cnt, 8'hFF);
      run_reset_mid_cipher();
      run_txn(3, 1'b0, 5, 0, 2, 4);
      check64("seq_after_reset", seq_cnt, 16'd1);
      finish_run();
   end

   initial begin
      #2_000_000;
      check64("global_watchdog", 64'd0, 64'd1);
      finish_run();
   end

endmodule
